openram_stream_reader: RTL and testbench

- Read-side companion to the Wishbone RAM bridge.
- Drives OpenRAM port 1 (read-only) to fetch a contiguous block of words, starting at a programmed address for a programmed length.
- Buffers the words in a small FIFO and presents them on a valid/ready stream.
- Sits between the RAM macro's second port and a streaming consumer (display/DMA/accelerator), so it never contends with Wishbone traffic on port 0.

---
 rtl/openram_pkg.sv | 10 +
 rtl/stream_fifo.sv | 51 +++++
 rtl/openram_stream_reader.sv | 109 ++++++++++
 tb/tb_openram_stream_reader.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/openram_pkg.sv
// openram_pkg: shared OpenRAM constants and the reader controller state encoding.
//   OPENRAM_ADDR_WIDTH / OPENRAM_DATA_WIDTH : default macro geometry, shared with the Wishbone bridge
//   OPENRAM_READ_LATENCY                    : cycles from csb1/addr1 sample to valid dout1
//   state_t                                 : IDLE, RUN, DRAIN
package openram_pkg;
   localparam int OPENRAM_ADDR_WIDTH   = 8;
   localparam int OPENRAM_DATA_WIDTH   = 32;
   localparam int OPENRAM_READ_LATENCY = 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: first-word fall-through FIFO with occupancy count and synchronous flush.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : empties the FIFO at the next edge (overrides push/pop)
//   push_i, data_i : write port, ignored when full
//   pop_i          : consume head, ignored when empty
//   data_o/valid_o : head word (zero when empty) and non-empty flag
//   count_o        : current occupancy
module stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
   assign do_pop  = pop_i && valid_o;
   assign valid_o = cnt_q != '0;
   assign data_o  = valid_o ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end

   always_ff @(posedge clk_i)
      if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/openram_stream_reader.sv
// openram_stream_reader: streams a contiguous block of words out of OpenRAM port 1.
//   wb_clk_i, wb_rst_n_i     : clock, asynchronous active-low reset
//   start_i, abort_i         : start pulse (IDLE only), transfer cancel
//   base_addr_i, len_i       : first word address and word count, latched on start
//   busy_o, done_o           : transfer active, one-cycle completion pulse
//   clk1, csb1, addr1, din1  : OpenRAM read port
//   data_o, valid_o, ready_i : output stream
module openram_stream_reader
   import openram_pkg::*;
#(
   parameter int ADDR_WIDTH = OPENRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = OPENRAM_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  clk1,
   output logic                  csb1,
   output logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] din1,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic                  inflight_q, inflight_d;
   logic                  done_q, done_d;
   logic [CW-1:0]         fifo_count;
   logic                  abort, issue, push;

   // Reserve a FIFO slot for the word still in flight so a return is never dropped.
   assign abort  = abort_i && (state_q != IDLE);
   assign issue  = (state_q == RUN) && (rem_q != '0) &&
                   ((CW+1)'(fifo_count) + (CW+1)'(inflight_q) < (CW+1)'(FIFO_DEPTH));
   assign push   = inflight_q && !abort;
   assign clk1   = wb_clk_i;
   assign csb1   = !issue;
   assign addr1  = addr_q;
   assign busy_o = state_q != IDLE;
   assign done_o = done_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = issue ? addr_q + 1'b1 : addr_q;
      rem_d      = issue ? rem_q - 1'b1 : rem_q;
      inflight_d = issue && !abort;
      done_d     = 1'b0;
      case (state_q)
         IDLE:
            if (start_i) begin
               if (len_i != '0) begin
                  state_d = RUN;
                  addr_d  = base_addr_i;
                  rem_d   = len_i;
               end else begin
                  done_d = 1'b1;
               end
            end
         RUN:
            if (abort) state_d = IDLE;
            else if (issue && rem_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
         DRAIN:
            if (abort) begin
               state_d = IDLE;
            end else if (!inflight_q && !valid_o) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
      if (!wb_rst_n_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
      end

   stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_n_i (wb_rst_n_i),
      .flush_i (abort),
      .push_i  (push),
      .data_i  (din1),
      .pop_i   (ready_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .count_o (fifo_count)
   );
endmodule

// File: tb/tb_openram_stream_reader.sv
// tb_openram_stream_reader: directed self-checking bench with a one-cycle-latency RAM model.
module tb_openram_stream_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [7:0]  base_addr_i = '0;
   logic [8:0]  len_i = '0;
   logic        busy_o, done_o, clk1, csb1, valid_o;
   logic        ready_i = 1'b1;
   logic [7:0]  addr1;
   logic [31:0] din1 = '0;
   logic [31:0] data_o;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   logic [7:0]  rd_addr [$];
   int          rd_cyc [$];
   logic [31:0] words [$];
   int          wd_cyc [$];
   int          done_cnt, done_busy, busy_seen;

   openram_stream_reader dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .clk1        (clk1),
      .csb1        (csb1),
      .addr1       (addr1),
      .din1        (din1),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ram_word(input logic [7:0] a);
      return {24'hDA7A00, a};
   endfunction

   always @(posedge clk1)
      if (!csb1) din1 <= ram_word(addr1);

   always @(negedge clk)
      if (rst_n) begin
         if (!csb1) begin
            rd_addr.push_back(addr1);
            rd_cyc.push_back(cyc);
         end
         if (valid_o && ready_i) begin
            words.push_back(data_o);
            wd_cyc.push_back(cyc);
         end
         if (done_o) begin
            done_cnt++;
            if (busy_o) done_busy++;
         end
         if (busy_o) busy_seen++;
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      rd_addr.delete();
      rd_cyc.delete();
      words.delete();
      wd_cyc.delete();
      done_cnt = 0;
      done_busy = 0;
      busy_seen = 0;
   endtask

   task automatic do_start(input logic [7:0] b, input logic [8:0] l, output int s);
      base_addr_i = b;
      len_i = l;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      start_i = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      for (int i = 0; i < 300 && done_cnt == 0; i++) step();
      ok = done_cnt != 0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      tests_run++;
      if ({csb1, addr1, busy_o, done_o, valid_o, data_o} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL reset_values: csb1=%b addr1=%h busy=%b done=%b valid=%b data=%h, want 1 00 0 0 0 0",
                  csb1, addr1, busy_o, done_o, valid_o, data_o);
      end
   endtask

   task automatic test_basic();
      int s;
      bit ok;
      clear_log();
      ready_i = 1'b1;
      do_start(8'h10, 9'd4, s);
      tests_run++;
      if (busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_busy: busy_o=%b want 1", busy_o);
      end
      wait_done(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL basic_done_timeout: done_cnt=%0d want 1", done_cnt);
      end
      tests_run++;
      if (rd_addr.size() != 4 || words.size() != 4) begin
         tests_failed++;
         $display("FAIL basic_counts: reads=%0d words=%0d want 4 4", rd_addr.size(), words.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rd_addr[i] !== 8'h10 + 8'(i) || rd_cyc[i] != s + i) begin
               tests_failed++;
               $display("FAIL basic_read%0d: addr=%h cyc=%0d want %h %0d", i, rd_addr[i], rd_cyc[i], 8'h10 + 8'(i), s + i);
            end
            tests_run++;
            if (words[i] !== ram_word(8'h10 + 8'(i)) || wd_cyc[i] != s + 2 + i) begin
               tests_failed++;
               $display("FAIL basic_word%0d: data=%h cyc=%0d want %h %0d", i, words[i], wd_cyc[i], ram_word(8'h10 + 8'(i)), s + 2 + i);
            end
         end
      end
      tests_run++;
      if (done_cnt != 1 || done_busy != 0 || busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_done: pulses=%0d busy_at_done=%0d busy_o=%b want 1 0 0", done_cnt, done_busy, busy_o);
      end
   endtask

   task automatic test_wrap();
      int s;
      bit ok;
      logic [7:0] exp_a [4];
      exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      clear_log();
      do_start(8'hFE, 9'd4, s);
      wait_done(ok);
      tests_run++;
      if (!ok || rd_addr.size() != 4 || words.size() != 4) begin
         tests_failed++;
         $display("FAIL wrap_counts: done=%0d reads=%0d words=%0d want 1 4 4", done_cnt, rd_addr.size(), words.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rd_addr[i] !== exp_a[i] || words[i] !== ram_word(exp_a[i])) begin
               tests_failed++;
               $display("FAIL wrap_%0d: addr=%h data=%h want %h %h", i, rd_addr[i], words[i], exp_a[i], ram_word(exp_a[i]));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int s;
      bit ok;
      clear_log();
      ready_i = 1'b0;
      do_start(8'h00, 9'd10, s);
      repeat (10) step();
      tests_run++;
      if (rd_addr.size() != 4 || csb1 !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_reads_stall: reads=%0d csb1=%b want 4 1", rd_addr.size(), csb1);
      end
      tests_run++;
      if (valid_o !== 1'b1 || data_o !== ram_word(8'h00)) begin
         tests_failed++;
         $display("FAIL bp_head: valid=%b data=%h want 1 %h", valid_o, data_o, ram_word(8'h00));
      end
      repeat (3) step();
      tests_run++;
      if (valid_o !== 1'b1 || data_o !== ram_word(8'h00) || rd_addr.size() != 4) begin
         tests_failed++;
         $display("FAIL bp_stable: valid=%b data=%h reads=%0d want 1 %h 4", valid_o, data_o, rd_addr.size(), ram_word(8'h00));
      end
      ready_i = 1'b1;
      wait_done(ok);
      tests_run++;
      if (!ok || rd_addr.size() != 10 || words.size() != 10) begin
         tests_failed++;
         $display("FAIL bp_counts: done=%0d reads=%0d words=%0d want 1 10 10", done_cnt, rd_addr.size(), words.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (rd_addr[i] !== 8'(i) || words[i] !== ram_word(8'(i))) begin
               tests_failed++;
               $display("FAIL bp_%0d: addr=%h data=%h want %h %h", i, rd_addr[i], words[i], 8'(i), ram_word(8'(i)));
            end
         end
      end
   endtask

   task automatic test_len0_and_restart();
      int s, s2;
      bit ok;
      clear_log();
      do_start(8'h33, 9'd0, s);
      tests_run++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL len0_pulse: done=%b busy=%b want 1 0", done_o, busy_o);
      end
      repeat (4) step();
      tests_run++;
      if (done_cnt != 1 || rd_addr.size() != 0 || busy_seen != 0) begin
         tests_failed++;
         $display("FAIL len0_quiet: pulses=%0d reads=%0d busy_cycles=%0d want 1 0 0", done_cnt, rd_addr.size(), busy_seen);
      end
      clear_log();
      do_start(8'h40, 9'd8, s);
      step();
      do_start(8'h80, 9'd3, s2);
      wait_done(ok);
      tests_run++;
      if (!ok || done_cnt != 1 || rd_addr.size() != 8 || words.size() != 8) begin
         tests_failed++;
         $display("FAIL restart_counts: done=%0d reads=%0d words=%0d want 1 8 8", done_cnt, rd_addr.size(), words.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (rd_addr[i] !== 8'h40 + 8'(i) || words[i] !== ram_word(8'h40 + 8'(i))) begin
               tests_failed++;
               $display("FAIL restart_%0d: addr=%h data=%h want %h", i, rd_addr[i], words[i], 8'h40 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_abort();
      int s;
      bit ok;
      clear_log();
      do_start(8'h20, 9'd8, s);
      for (int i = 0; i < 50 && rd_addr.size() < 3; i++) begin
         @(negedge clk);
         #1;
      end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      tests_run++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_state: busy=%b valid=%b done=%b want 0 0 0", busy_o, valid_o, done_o);
      end
      repeat (10) step();
      tests_run++;
      if (rd_addr.size() != 3 || done_cnt != 0 || valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_quiet: reads=%0d done=%0d valid=%b want 3 0 0", rd_addr.size(), done_cnt, valid_o);
      end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      clear_log();
      do_start(8'h90, 9'd3, s);
      wait_done(ok);
      tests_run++;
      if (!ok || rd_addr.size() != 3 || words.size() != 3) begin
         tests_failed++;
         $display("FAIL abort_restart_counts: done=%0d reads=%0d words=%0d want 1 3 3", done_cnt, rd_addr.size(), words.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rd_addr[i] !== 8'h90 + 8'(i) || words[i] !== ram_word(8'h90 + 8'(i))) begin
               tests_failed++;
               $display("FAIL abort_restart_%0d: addr=%h data=%h want %h", i, rd_addr[i], words[i], 8'h90 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int s;
      clear_log();
      do_start(8'h50, 9'd8, s);
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      test_reset();
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      repeat (10) step();
      tests_run++;
      if (rd_addr.size() != 0 || words.size() != 0 || busy_seen != 0 || done_cnt != 0) begin
         tests_failed++;
         $display("FAIL reset_mid_quiet: reads=%0d words=%0d busy_cycles=%0d done=%0d want 0 0 0 0",
                  rd_addr.size(), words.size(), busy_seen, done_cnt);
      end
   endtask

   initial begin
      clear_log();
      #1;
      test_reset();
      repeat (3) step();
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len0_and_restart();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
